fir_requant_decim: RTL and testbench

Downstream stage for the `fir` filter core. Takes the FIR core's full-precision signed accumulator output each sample and rounds, right-shifts and saturates it back to audio sample width. It then decimates by a runtime-programmable factor and presents results on a ready/valid stream through a small FIFO. Sits between the FIR bank and the output serializer / next DSP stage.

---
 rtl/fir_pkg.sv | 38 +++
 rtl/sample_fifo.sv | 69 ++++++
 rtl/fir_requant_decim.sv | 138 +++++++++++++
 tb/tb_fir_requant_decim.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR bank and its requantizing stages.
package fir_pkg;

  localparam int FIR_OUT_W = 16;
  localparam int FIR_ACC_W = 58;

  typedef struct packed {
    logic signed [FIR_OUT_W-1:0] val;
    logic                        sat;
  } sat_round_t;

  // Round-half-up, arithmetic right shift by 'shift', then clamp to a signed
  // out_w-bit range. The 64-bit working width holds any accumulator up to 63
  // bits plus the rounding constant without overflow. out_w must not exceed
  // FIR_OUT_W.
  function automatic sat_round_t sat_round(input logic signed [63:0] x,
                                           input int shift,
                                           input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_round_t         res;
    r   = (x + (64'sd1 <<< (shift - 1))) >>> shift;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    res.sat = 1'b1;
    if (r > hi) begin
      res.val = FIR_OUT_W'(hi);
    end else if (r < lo) begin
      res.val = FIR_OUT_W'(lo);
    end else begin
      res.val = FIR_OUT_W'(r);
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous W x DEPTH FIFO with registered storage; head is read directly
// from storage so the output has no combinational path from the write side.
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign rdata = mem_q[rd_ptr_q];

  // Accept pop when non-empty; accept push when not full or when a pop frees a slot
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer, count and storage registers; storage cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_requant_decim.sv
// Requantizes the FIR accumulator to sample width, decimates by a runtime
// factor and streams results out through a small FIFO.
// Optional feature macro: FIR_REQUANT_SATCNT_EN adds the saturating
// sat_count port counting every clamped sample.
module fir_requant_decim
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_ACC_W,
  parameter int OUT_W      = FIR_OUT_W,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int DECIM_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  in,
  input  logic                    in_valid,
  input  logic [DECIM_W-1:0]      decim,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
`ifdef FIR_REQUANT_SATCNT_EN
  ,
  output logic [15:0]             sat_count
`endif
);

  sat_round_t               rq;
  logic signed [OUT_W-1:0]  data_p1_d, data_p1_q;
  logic                     sat_p1_d;
  logic                     vld_p1_d, vld_p1_q;
  logic [DECIM_W-1:0]       dcnt_d, dcnt_q;
  logic                     overflow_d, overflow_q;
  logic                     sel;
  logic                     pop;
  logic                     fifo_empty, fifo_full;
  logic [OUT_W-1:0]         fifo_rdata;

  // ---- stage p0 -> p1: round, shift, saturate ----

  // Requantize the incoming accumulator sample
  always_comb begin
    rq        = sat_round(64'(in), SHIFT, OUT_W);
    data_p1_d = OUT_W'(rq.val);
    sat_p1_d  = rq.sat;
    vld_p1_d  = in_valid;
  end

  // Valid bit of the requantized stage; reset flushes it so in-flight samples are lost
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  // Requantized sample payload, qualified by vld_p1_q
  always_ff @(posedge clk) begin
    data_p1_q <= data_p1_d;
  end

  // ---- stage p1 -> FIFO: decimate, push, overflow ----

  // Keep every (decim+1)th valid sample; decim is only sampled on reload
  always_comb begin
    sel        = vld_p1_q && (dcnt_q == '0);
    pop        = out_valid && out_ready;
    dcnt_d     = dcnt_q;
    if (vld_p1_q) begin
      dcnt_d = (dcnt_q == '0) ? decim : (dcnt_q - DECIM_W'(1));
    end
    overflow_d = overflow_q || (sel && fifo_full && !pop);
  end

  // Decimation counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      dcnt_q     <= dcnt_d;
      overflow_q <= overflow_d;
    end
  end

  sample_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (sel),
    .pop   (pop),
    .wdata (data_p1_q),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_data  = fifo_rdata;
  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

`ifdef FIR_REQUANT_SATCNT_EN
  logic        sat_p1_q;
  logic [15:0] sat_count_d, sat_count_q;

  // Saturation flag travels with the p1 payload
  always_ff @(posedge clk) begin
    sat_p1_q <= sat_p1_d;
  end

  // Count every clamped valid sample, selected or not; stick at all-ones
  always_comb begin
    sat_count_d = sat_count_q;
    if (vld_p1_q && sat_p1_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  // Saturation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`else
  logic sat_unused;
  assign sat_unused = sat_p1_d;
`endif

endmodule

// File: tb/tb_fir_requant_decim.sv
// Self-checking bench for fir_requant_decim: directed scenarios plus
// randomized streams checked against an arithmetic reference model.
module tb_fir_requant_decim;

  localparam int IN_W       = 58;
  localparam int OUT_W      = 16;
  localparam int SHIFT      = 15;
  localparam int FIFO_DEPTH = 4;
  localparam int DECIM_W    = 8;
  localparam longint ONE    = 32768;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic signed [IN_W-1:0]  in_s = '0;
  logic                    in_valid = 1'b0;
  logic [DECIM_W-1:0]      decim = '0;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    overflow;
`ifdef FIR_REQUANT_SATCNT_EN
  logic [15:0]             sat_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int got_q[$];

  always #5 clk = ~clk;

  fir_requant_decim #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .SHIFT      (SHIFT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DECIM_W    (DECIM_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_s),
    .in_valid  (in_valid),
    .decim     (decim),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
`ifdef FIR_REQUANT_SATCNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  // Record every accepted output; inputs only change just after posedge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(int'(out_data));
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // Reference: round half up of x / 2^SHIFT using floor division, then clamp.
  function automatic int model_q(input longint x);
    longint num, den, q, hi, lo;
    den = longint'(1) << SHIFT;
    num = x + den / 2;
    q   = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (q > hi) return int'(hi);
    if (q < lo) return int'(lo);
    return int'(q);
  endfunction

  function automatic longint rand_sample();
    longint r;
    if ($urandom_range(0, 3) == 0) begin
      r = (longint'($urandom_range(0, 200)) - 100) * ONE + 16383 + longint'($urandom_range(0, 2));
    end else begin
      r = longint'({$urandom, $urandom});
      r = r >>> $urandom_range(6, 45);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic send(input longint v);
    in_s     = IN_W'(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_data !== 16'sd0) $display("FAIL reset_data: got %0d expected 0", out_data); else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else pass_cnt++;
`ifdef FIR_REQUANT_SATCNT_EN
    total_cnt++;
    if (sat_count !== 16'd0) $display("FAIL reset_satcnt: got %0d expected 0", sat_count); else pass_cnt++;
`endif
  endtask

  task automatic test_rounding();
    longint vals[4] = '{32768000, 16384, -16384, -16385};
    int     exp_v[4] = '{1000, 1, 0, -1};
    do_reset();
    decim     = '0;
    out_ready = 1'b0;
    send(7 * ONE);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL latency_n: got valid %b expected 0", out_valid); else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 16'sd7)
      $display("FAIL latency_n1: got valid %b data %0d expected valid 1 data 7", out_valid, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    settle(3);
    got_q.delete();
    foreach (vals[i]) send(vals[i]);
    settle(6);
    total_cnt++;
    if (got_q.size() != 4) $display("FAIL round_count: got %0d expected 4", got_q.size()); else pass_cnt++;
    foreach (exp_v[i]) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] != exp_v[i])
        $display("FAIL round_val[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 0, exp_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    decim     = '0;
    out_ready = 1'b1;
    send(longint'(1) << 40);
    send(-(longint'(1) << 40));
    settle(6);
    total_cnt++;
    if (got_q.size() != 2 || got_q[0] != 32767)
      $display("FAIL sat_pos: got %0d expected 32767", (got_q.size() > 0) ? got_q[0] : 0);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() != 2 || got_q[1] != -32768)
      $display("FAIL sat_neg: got %0d expected -32768", (got_q.size() > 1) ? got_q[1] : 0);
    else pass_cnt++;
`ifdef FIR_REQUANT_SATCNT_EN
    total_cnt++;
    if (sat_count !== 16'd2) $display("FAIL satcnt_two: got %0d expected 2", sat_count); else pass_cnt++;
    decim    = 8'd255;
    in_s     = IN_W'(longint'(1) << 40);
    in_valid = 1'b1;
    repeat (70000) step();
    in_valid = 1'b0;
    settle(3);
    total_cnt++;
    if (sat_count !== 16'hFFFF) $display("FAIL satcnt_cap: got %0d expected 65535", sat_count); else pass_cnt++;
`endif
  endtask

  task automatic test_decimation();
    do_reset();
`ifdef FIR_REQUANT_SATCNT_EN
    total_cnt++;
    if (sat_count !== 16'd0) $display("FAIL satcnt_clear: got %0d expected 0", sat_count); else pass_cnt++;
`endif
    decim     = 8'd3;
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) send(longint'(k) * ONE);
    settle(8);
    total_cnt++;
    if (got_q.size() != 2 || got_q[0] != 1 || got_q[1] != 5)
      $display("FAIL decim3: got %0d outputs first %0d second %0d expected 2 outputs 1 5", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 0, (got_q.size() > 1) ? got_q[1] : 0);
    else pass_cnt++;
    do_reset();
    decim = 8'd3;
    send(1 * ONE);
    send(2 * ONE);
    decim = 8'd1;
    for (int k = 3; k <= 8; k++) send(longint'(k) * ONE);
    settle(8);
    total_cnt++;
    if (got_q.size() != 3 || got_q[0] != 1 || got_q[1] != 5 || got_q[2] != 7)
      $display("FAIL decim_change: got %0d outputs last %0d expected 1 5 7", got_q.size(),
               (got_q.size() > 0) ? got_q[got_q.size()-1] : 0);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    decim     = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_s     = IN_W'(longint'(10 + i) * ONE);
      in_valid = 1'b1;
      step();
      if (i == 4) begin
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL ovf_early: got %b expected 0", overflow); else pass_cnt++;
      end
      if (i == 5) begin
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow); else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 16'sd10)
      $display("FAIL ovf_head: got valid %b data %0d expected valid 1 data 10", out_valid, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    settle(8);
    total_cnt++;
    if (got_q.size() != 4) $display("FAIL ovf_count: got %0d expected 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] != 10 + i)
        $display("FAIL ovf_val[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 0, 10 + i);
      else pass_cnt++;
    end
    total_cnt++;
    if (out_valid !== 1'b0 || overflow !== 1'b1)
      $display("FAIL ovf_after: got valid %b overflow %b expected valid 0 overflow 1", out_valid, overflow);
    else pass_cnt++;
  endtask

  task automatic test_push_pop_full();
    int exp_v[5] = '{20, 21, 22, 23, 24};
    do_reset();
    decim     = '0;
    out_ready = 1'b0;
    for (int k = 20; k <= 23; k++) send(longint'(k) * ONE);
    settle(3);
    send(24 * ONE);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (out_data !== 16'sd21 || overflow !== 1'b0)
      $display("FAIL full_pushpop: got head %0d overflow %b expected head 21 overflow 0", out_data, overflow);
    else pass_cnt++;
    out_ready = 1'b1;
    settle(8);
    total_cnt++;
    if (got_q.size() != 5) $display("FAIL full_count: got %0d expected 5", got_q.size()); else pass_cnt++;
    foreach (exp_v[i]) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] != exp_v[i])
        $display("FAIL full_val[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 0, exp_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    decim     = 8'd3;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(longint'(40 + i) * ONE);
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL mid_queued: got valid %b expected 1", out_valid); else pass_cnt++;
    reset    = 1'b1;
    in_s     = IN_W'(99 * ONE);
    in_valid = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 16'sd0)
      $display("FAIL mid_reset: got valid %b overflow %b data %0d expected 0 0 0", out_valid, overflow, out_data);
    else pass_cnt++;
    settle(3);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_ignored: got valid %b expected 0", out_valid); else pass_cnt++;
    got_q.delete();
    out_ready = 1'b1;
    send(77 * ONE);
    send(78 * ONE);
    settle(8);
    total_cnt++;
    if (got_q.size() != 1 || got_q[0] != 77)
      $display("FAIL mid_first: got %0d outputs first %0d expected 1 output 77", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int b = 0; b < 5; b++) begin
      int     exp_q[$];
      int     cnt;
      int     d;
      longint v;
      bool_bp: begin end
      do_reset();
      cnt   = 0;
      d     = (b < 4) ? $urandom_range(0, 5) : $urandom_range(7, 15);
      decim = DECIM_W'(d);
      out_ready = 1'b1;
      for (int c = 0; c < 96; c++) begin
        if (b == 4) out_ready = 1'($urandom_range(0, 1));
        if (b == 4 || $urandom_range(0, 3) != 0) begin
          v = rand_sample();
          if (cnt % (d + 1) == 0) exp_q.push_back(model_q(v));
          cnt++;
          in_s     = IN_W'(v);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      settle(10);
      total_cnt++;
      if (got_q.size() != exp_q.size())
        $display("FAIL rand%0d_count: got %0d expected %0d", b, got_q.size(), exp_q.size());
      else pass_cnt++;
      foreach (exp_q[i]) begin
        total_cnt++;
        if (i >= got_q.size() || got_q[i] != exp_q[i])
          $display("FAIL rand%0d_val[%0d]: got %0d expected %0d", b, i,
                   (i < got_q.size()) ? got_q[i] : 0, exp_q[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (overflow !== 1'b0) $display("FAIL rand%0d_overflow: got %b expected 0", b, overflow); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_decimation();
    test_overflow();
    test_push_pop_full();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
